// File: rtl/decode_stage.sv
// decode_stage: register file, opcode decode, load-use stall and ID/EX register
// Ports: i_clk/i_reset (sync, active-high), i_step advance enable,
//   i_instruction/i_valid from IF/ID, i_wb_* writeback port,
//   i_ex_mem_read/i_ex_rt load in EX, i_flush squash, i_select_reg_dir debug select,
//   o_stall front-end hold, o_data_tx_debug debug read, o_* registered ID/EX fields.
module decode_stage #(
    parameter int NB     = 32,
    parameter int REGS   = 5,
    parameter int INBITS = 16,
    parameter int CTRLNB = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_step,
    input  logic [NB-1:0]     i_instruction,
    input  logic              i_valid,
    input  logic              i_wb_en,
    input  logic [REGS-1:0]   i_wb_addr,
    input  logic [NB-1:0]     i_wb_data,
    input  logic              i_ex_mem_read,
    input  logic [REGS-1:0]   i_ex_rt,
    input  logic              i_flush,
    input  logic [REGS-1:0]   i_select_reg_dir,
    output logic              o_stall,
    output logic [NB-1:0]     o_data_tx_debug,
    output logic              o_valid,
    output logic [NB-1:0]     o_data_a,
    output logic [NB-1:0]     o_data_b,
    output logic [NB-1:0]     o_extension_result,
    output logic [REGS-1:0]   o_rs,
    output logic [REGS-1:0]   o_rt,
    output logic [REGS-1:0]   o_rd,
    output logic [REGS-1:0]   o_dest,
    output logic [CTRLNB-1:0] o_op_code,
    output logic [CTRLNB-1:0] o_funct_code,
    output logic              o_alu_src,
    output logic              o_reg_write,
    output logic              o_mem_read,
    output logic              o_mem_write
);
    localparam logic [CTRLNB-1:0] OP_R    = CTRLNB'('h00);
    localparam logic [CTRLNB-1:0] OP_LW   = CTRLNB'('h23);
    localparam logic [CTRLNB-1:0] OP_SW   = CTRLNB'('h2B);
    localparam logic [CTRLNB-1:0] OP_ADDI = CTRLNB'('h08);
    localparam logic [CTRLNB-1:0] OP_ANDI = CTRLNB'('h0C);
    localparam logic [CTRLNB-1:0] OP_ORI  = CTRLNB'('h0D);
    localparam logic [CTRLNB-1:0] OP_LUI  = CTRLNB'('h0F);

    logic [NB-1:0]     rf [2**REGS];
    logic [CTRLNB-1:0] op, funct;
    logic [REGS-1:0]   rs, rt, rd, dest;
    logic [INBITS-1:0] imm;
    logic [NB-1:0]     data_a, data_b, ext;
    logic              alu_src, reg_write, mem_read, mem_write, uses_rt, bubble;

    assign op    = i_instruction[NB-1 -: CTRLNB];
    assign rs    = i_instruction[INBITS+2*REGS-1 -: REGS];
    assign rt    = i_instruction[INBITS+REGS-1 -: REGS];
    assign rd    = i_instruction[INBITS-1 -: REGS];
    assign funct = i_instruction[CTRLNB-1:0];
    assign imm   = i_instruction[INBITS-1:0];

    // write-through bypass so a same-cycle WB needs no stall
    assign data_a = (rs == '0) ? '0 : (i_wb_en && i_wb_addr == rs) ? i_wb_data : rf[rs];
    assign data_b = (rt == '0) ? '0 : (i_wb_en && i_wb_addr == rt) ? i_wb_data : rf[rt];
    assign o_data_tx_debug = (i_select_reg_dir == '0) ? '0 : rf[i_select_reg_dir];

    always_comb begin
        alu_src   = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        dest      = '0;
        ext       = {{(NB-INBITS){imm[INBITS-1]}}, imm};
        case (op)
            OP_R: begin
                reg_write = 1'b1;
                dest      = rd;
            end
            OP_LW: begin
                mem_read  = 1'b1;
                reg_write = 1'b1;
                alu_src   = 1'b1;
                dest      = rt;
            end
            OP_SW: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                dest      = rt;
                ext       = (op == OP_LUI) ? {imm, {(NB-INBITS){1'b0}}} :
                            (op == OP_ADDI) ? ext : {{(NB-INBITS){1'b0}}, imm};
            end
            default: ;
        endcase
    end

    assign uses_rt = (op == OP_R) || (op == OP_SW);
    assign o_stall = i_valid && i_ex_mem_read && (i_ex_rt != '0) &&
                     (i_ex_rt == rs || (uses_rt && i_ex_rt == rt)) && !i_flush;
    assign bubble  = i_flush || o_stall || !i_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 2**REGS; i++) rf[i] <= '0;
            o_valid            <= 1'b0;
            o_data_a           <= '0;
            o_data_b           <= '0;
            o_extension_result <= '0;
            o_rs               <= '0;
            o_rt               <= '0;
            o_rd               <= '0;
            o_dest             <= '0;
            o_op_code          <= '0;
            o_funct_code       <= '0;
            o_alu_src          <= 1'b0;
            o_reg_write        <= 1'b0;
            o_mem_read         <= 1'b0;
            o_mem_write        <= 1'b0;
        end else if (i_step) begin
            if (i_wb_en && i_wb_addr != '0) rf[i_wb_addr] <= i_wb_data;
            o_valid            <= !bubble;
            o_data_a           <= bubble ? '0 : data_a;
            o_data_b           <= bubble ? '0 : data_b;
            o_extension_result <= bubble ? '0 : ext;
            o_rs               <= bubble ? '0 : rs;
            o_rt               <= bubble ? '0 : rt;
            o_rd               <= bubble ? '0 : rd;
            o_dest             <= bubble ? '0 : dest;
            o_op_code          <= bubble ? '0 : op;
            o_funct_code       <= bubble ? '0 : funct;
            o_alu_src          <= !bubble && alu_src;
            o_reg_write        <= !bubble && reg_write;
            o_mem_read         <= !bubble && mem_read;
            o_mem_write        <= !bubble && mem_write;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage
module tb_decode_stage;
    typedef struct packed {
        logic        v;
        logic [31:0] a, b, ext;
        logic [4:0]  rs, rt, rd, dest;
        logic [5:0]  op, fn;
        logic        alu, rw, mr, mw;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, step, valid, wb_en, ex_mr, flush;
    logic [31:0] instr, wb_data;
    logic [4:0]  wb_addr, ex_rt, sel;
    logic        o_stall, o_valid, o_alu_src, o_reg_write, o_mem_read, o_mem_write;
    logic [31:0] o_dbg, o_data_a, o_data_b, o_ext;
    logic [4:0]  o_rs, o_rt, o_rd, o_dest;
    logic [5:0]  o_op, o_fn;

    logic [31:0] rf_m [32];
    exp_t        last;
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .i_clk(clk), .i_reset(reset), .i_step(step), .i_instruction(instr), .i_valid(valid),
        .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .i_ex_mem_read(ex_mr), .i_ex_rt(ex_rt), .i_flush(flush), .i_select_reg_dir(sel),
        .o_stall(o_stall), .o_data_tx_debug(o_dbg), .o_valid(o_valid),
        .o_data_a(o_data_a), .o_data_b(o_data_b), .o_extension_result(o_ext),
        .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_dest(o_dest),
        .o_op_code(o_op), .o_funct_code(o_fn),
        .o_alu_src(o_alu_src), .o_reg_write(o_reg_write),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write)
    );

    function automatic logic [31:0] rd_port(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return rf_m[a];
    endfunction

    function automatic logic exp_stall();
        logic [5:0] op = instr[31:26];
        logic       ur = (op == 6'h00) || (op == 6'h2B);
        return valid && ex_mr && ex_rt != 0 &&
               (ex_rt == instr[25:21] || (ur && ex_rt == instr[20:16])) && !flush;
    endfunction

    function automatic exp_t model();
        exp_t        e = '0;
        logic [15:0] imm = instr[15:0];
        if (reset) return '0;
        if (!step) return last;
        if (flush || exp_stall() || !valid) return '0;
        e.v = 1'b1;
        e.rs = instr[25:21];
        e.rt = instr[20:16];
        e.rd = instr[15:11];
        e.op = instr[31:26];
        e.fn = instr[5:0];
        e.a = rd_port(e.rs);
        e.b = rd_port(e.rt);
        e.ext = {{16{imm[15]}}, imm};
        case (e.op)
            6'h00: begin e.rw = 1; e.dest = e.rd; end
            6'h23: begin e.mr = 1; e.rw = 1; e.alu = 1; e.dest = e.rt; end
            6'h2B: begin e.mw = 1; e.alu = 1; end
            6'h08: begin e.rw = 1; e.alu = 1; e.dest = e.rt; end
            6'h0C, 6'h0D: begin e.rw = 1; e.alu = 1; e.dest = e.rt; e.ext = {16'h0, imm}; end
            6'h0F: begin e.rw = 1; e.alu = 1; e.dest = e.rt; e.ext = {imm, 16'h0}; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic idle();
        reset = 0; step = 1; valid = 0; instr = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        ex_mr = 0; ex_rt = 0; flush = 0; sel = 0;
    endtask

    // called at a negedge with inputs already driven; returns at the next negedge
    task automatic tick(input string tag);
        exp_t        e, got;
        logic        st;
        logic [31:0] dbg;
        #1;
        st  = exp_stall();
        dbg = (sel == 0) ? 32'h0 : rf_m[sel];
        checks++;
        assert (o_stall === st) else begin
            errors++;
            $error("FAIL %s stall: observed %b expected %b", tag, o_stall, st);
        end
        checks++;
        assert (o_dbg === dbg) else begin
            errors++;
            $error("FAIL %s debug: observed %h expected %h", tag, o_dbg, dbg);
        end
        e = model();
        sb.push_back(e);
        last = e;
        @(posedge clk);
        if (reset) for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
        else if (step && wb_en && wb_addr != 0) rf_m[wb_addr] = wb_data;
        #1;
        got = {o_valid, o_data_a, o_data_b, o_ext, o_rs, o_rt, o_rd, o_dest, o_op, o_fn,
               o_alu_src, o_reg_write, o_mem_read, o_mem_write};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            assert (got === e) else begin
                errors++;
                $error("FAIL %s idex: observed %h expected %h", tag, got, e);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
        last = '0;
        idle();
        @(negedge clk);
        reset = 1; tick("reset0");
        reset = 1; tick("reset1");
        idle(); valid = 1; instr = 32'h2001FFFB; tick("addi_neg");
        idle(); valid = 1; instr = 32'h34028001; tick("ori_zext");
        idle(); valid = 1; instr = 32'h3C031234; tick("lui");
        idle(); valid = 1; instr = 32'h00A53020; wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
        tick("add_bypass");
        idle(); valid = 1; instr = 32'h00A53020; wb_en = 1; wb_addr = 0; wb_data = 32'h1; sel = 0;
        tick("r0_write");
        idle(); valid = 1; instr = 32'h00003020; sel = 5; tick("dbg_r5");
        idle(); valid = 1; instr = 32'h00A03020; ex_mr = 1; ex_rt = 5; tick("loaduse_rs");
        idle(); valid = 1; instr = 32'h00A03020; ex_mr = 1; ex_rt = 0; tick("loaduse_rt0");
        idle(); valid = 1; instr = 32'hAC250004; ex_mr = 1; ex_rt = 5; tick("sw_uses_rt");
        idle(); valid = 1; instr = 32'h20250001; ex_mr = 1; ex_rt = 5; tick("addi_no_rt");
        idle(); valid = 1; instr = 32'h00A03020; ex_mr = 1; ex_rt = 5; flush = 1; tick("stall_flush");
        idle(); valid = 1; instr = 32'h8C270008; tick("lw");
        for (int i = 0; i < 3; i++) begin
            idle(); step = 0; valid = 1; instr = 32'h00A03020; ex_mr = 1; ex_rt = 5;
            wb_en = 1; wb_addr = 7; wb_data = 32'h55;
            tick($sformatf("hold%0d", i));
        end
        idle(); valid = 1; instr = 32'h00E73020; sel = 7; tick("no_commit_r7");
        idle(); valid = 1; instr = 32'hFC0080FF; tick("unknown_op");
        idle(); valid = 0; instr = 32'h2001FFFB; tick("invalid");
        idle(); valid = 1; instr = 32'h00A03020; ex_mr = 1; ex_rt = 5; sel = 5; tick("pre_reset");
        idle(); reset = 1; valid = 1; instr = 32'h00A03020; ex_mr = 1; ex_rt = 5; sel = 5;
        tick("reset_in_stall");
        idle(); sel = 5; tick("after_reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, pipelined successor to the combinational decode stage. It sits between IF/ID and EX and contains:
- a register file with 2^REGS entries, written from WB and bypassed on the same-cycle write;
- local opcode decode and immediate extension;
- a load-use hazard detector that stalls the front end;
- the ID/EX pipeline register, which advances only on `i_step` and can be flushed.

## Interface
- `NB`, 32: datapath and instruction width.
- `REGS`, 5: register address width; the file holds 2^REGS entries.
- `INBITS`, 16: immediate field width.
- `CTRLNB`, 6: opcode and funct width.

- `i_clk` in 1: clock. This block uses one clock; reset is synchronous and active-high.
- `i_reset` in 1: synchronous, active-high reset.
- `i_step` in 1: pipeline advance enable. When low, every register holds.
- `i_instruction` in NB: instruction from IF/ID.
- `i_valid` in 1: IF/ID slot holds a real instruction.
- `i_wb_en` in 1: writeback write enable.
- `i_wb_addr` in REGS: writeback destination register.
- `i_wb_data` in NB: writeback data.
- `i_ex_mem_read` in 1: the instruction currently in EX is a load.
- `i_ex_rt` in REGS: destination register of the load in EX.
- `i_flush` in 1: squash the instruction entering ID/EX.
- `i_select_reg_dir` in REGS: debug register select.
- `o_stall` out 1: combinational; holds PC and IF/ID.
- `o_data_tx_debug` out NB: combinational read of the selected register, no bypass.
- `o_valid` out 1: ID/EX slot valid.
- `o_data_a`, `o_data_b` out NB: registered rs and rt operands.
- `o_extension_result` out NB: registered extended immediate.
- `o_rs`, `o_rt`, `o_rd` out REGS: registered register addresses.
- `o_dest` out REGS: registered write destination.
- `o_op_code`, `o_funct_code` out CTRLNB: registered opcode and funct fields.
- `o_alu_src`, `o_reg_write`, `o_mem_read`, `o_mem_write` out 1: registered control bits.

## Operation
Field extraction:
- op = `instr[NB-1 -: CTRLNB]`
- rs = `instr[INBITS+2*REGS-1 -: REGS]`
- rt = `instr[INBITS+REGS-1 -: REGS]`
- rd = `instr[INBITS-1 -: REGS]`
- funct = `instr[CTRLNB-1:0]`
- imm = `instr[INBITS-1:0]`

Decode. Any opcode not listed here decodes as NOP: all controls 0 and extension = sign.
- 0x00 R-type: `reg_write`=1, `alu_src`=0, dest=rd.
- 0x23 LW: `mem_read`, `reg_write`, `alu_src`=1, dest=rt, sign-extend.
- 0x2B SW: `mem_write`, `alu_src`=1, sign-extend.
- 0x08 ADDI: `reg_write`, `alu_src`, dest=rt, sign-extend.
- 0x0C ANDI and 0x0D ORI: as ADDI but zero-extend.
- 0x0F LUI: as ADDI with the immediate result = `{imm, NB-INBITS zeros}`.

Register file:
- Register 0 always reads 0 and ignores writes.
- A write commits on the `i_clk` edge when `i_step & i_wb_en & (i_wb_addr != 0)`.
- Read ports are combinational. If `i_wb_en` is set, `i_wb_addr != 0` and `i_wb_addr` equals the read address, the port returns `i_wb_data` (write-through bypass).
- The debug port has no bypass.

Hazard detection:
- `uses_rt` = R-type or SW.
- Load-use condition: `i_valid & i_ex_mem_read & (i_ex_rt != 0) & (i_ex_rt == rs | (uses_rt & i_ex_rt == rt))`.
- `o_stall` = load-use condition `& ~i_flush`.

ID/EX update on an `i_clk` edge, checked in priority order:
1. `i_reset`: all outputs go to 0. The register file clears to 0.
2. `~i_step`: hold.
3. `i_flush` or `o_stall` or `~i_valid`: load a bubble. `o_valid`=0, all four control bits 0, data fields don't-care and driven to 0.
4. Otherwise: load the decoded instruction with `o_valid`=1.

## Timing
- Decode latency is 1 cycle: an instruction presented at edge N appears on the ID/EX outputs after edge N+1 (when `i_step`=1).
- A WB write and a read of the same register in the same cycle return the new data through the bypass, with no extra stall.
- Load-use costs exactly 1 bubble. The next cycle EX holds a bubble, so `i_ex_mem_read`=0 and the stall releases.
- Flush and stall in the same cycle: a bubble is inserted and `o_stall`=0.
- Reset asserted mid-stall: all outputs return to 0 on the next edge and `o_stall` follows its inputs combinationally.
- `i_step`=0 while stalled: the ID/EX register holds and `o_stall` remains combinational.

## Test plan
- Reset, then ADDI r1,r0,-5 (0x2001FFFB) with `i_step`=1 → after one edge `o_extension_result`=0xFFFFFFFB, `o_dest`=1, `o_reg_write`=1, `o_alu_src`=1, `o_valid`=1.
- ORI r2,r0,0x8001 → `o_extension_result`=0x00008001. LUI r3,0x1234 → `o_extension_result`=0x12340000.
- WB write r5=0xDEADBEEF in the same cycle as ADD r6,r5,r5 → `o_data_a`=`o_data_b`=0xDEADBEEF. A write to r0 with 0x1 leaves `o_data_tx_debug`=0 for select 0.
- `i_ex_mem_read`=1, `i_ex_rt`=5, with ADD r6,r5,r0 → `o_stall`=1 and the next `o_valid`=0. With `i_ex_rt`=0 → `o_stall`=0.
- Stall condition with `i_flush`=1 → `o_stall`=0 and a bubble is loaded. With `i_step`=0 → all outputs hold their previous values for 3 cycles.
